// File: rtl/bsg_activation_vector_seq.sv
// Vector sequencer around a single-element blocking tanh unit: issues one angle at a time,
// bypasses saturated angles to +/-1.0, and collects results in element order.
module bsg_activation_vector_seq #(
  parameter int unsigned els_p       = 4,
  parameter int unsigned ang_width_p = 21,
  parameter int unsigned ans_width_p = 32,
  parameter int unsigned frac_bits_p = 16,
  parameter int          sat_ang_p   = 4 << 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [els_p*ang_width_p-1:0]   data_i,
  output logic                           ready_o,
  output logic [ang_width_p-1:0]         act_ang_o,
  output logic                           act_v_o,
  input  logic                           act_ready_i,
  input  logic [ans_width_p-1:0]         act_data_i,
  input  logic                           act_v_i,
  output logic                           act_ready_o,
  output logic                           v_o,
  output logic [els_p*ans_width_p-1:0]   data_o,
  input  logic                           yumi_i
);

  localparam int unsigned idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(els_p - 1);
  localparam logic signed [ang_width_p-1:0] sat_pos_lp = ang_width_p'(sat_ang_p);
  localparam logic signed [ang_width_p-1:0] sat_neg_lp = -sat_pos_lp;
  localparam logic [ans_width_p-1:0] one_lp = ans_width_p'(1) << frac_bits_p;
  localparam logic [ans_width_p-1:0] neg_one_lp = -one_lp;

  typedef enum logic [1:0] {eIDLE, eISSUE, eWAIT, eDONE} state_e;

  state_e state_q, state_d;
  logic [idx_width_lp-1:0] idx_q, idx_d;
  logic [ang_width_p-1:0] vec_q [els_p];
  logic [ans_width_p-1:0] res_q [els_p];

  logic                          capture;
  logic                          res_we;
  logic [ans_width_p-1:0]        res_wdata;
  logic signed [ang_width_p-1:0] cur_ang;
  logic                          bypass;
  logic                          last;

  assign cur_ang   = vec_q[idx_q];
  assign bypass    = (cur_ang >= sat_pos_lp) || (cur_ang <= sat_neg_lp);
  assign last      = (idx_q == last_idx_lp);
  assign act_ang_o = cur_ang;

  for (genvar k = 0; k < els_p; k++) begin : g_out
    assign data_o[k*ans_width_p +: ans_width_p] = res_q[k];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath registers; the input vector needs no reset since it is always captured before use
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < els_p; k++) res_q[k] <= '0;
    end else if (res_we) begin
      res_q[idx_q] <= res_wdata;
    end
    if (capture) begin
      for (int k = 0; k < els_p; k++) vec_q[k] <= data_i[k*ang_width_p +: ang_width_p];
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    res_we    = 1'b0;
    res_wdata = '0;
    unique case (state_q)
      eIDLE: begin
        if (v_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = eISSUE;
        end
      end
      eISSUE: begin
        if (bypass) begin
          res_we    = 1'b1;
          res_wdata = cur_ang[ang_width_p-1] ? neg_one_lp : one_lp;
          if (last) state_d = eDONE;
          else      idx_d   = idx_q + idx_width_lp'(1);
        end else if (act_ready_i) begin
          state_d = eWAIT;
        end
      end
      eWAIT: begin
        if (act_v_i) begin
          res_we    = 1'b1;
          res_wdata = act_data_i;
          if (last) begin
            state_d = eDONE;
          end else begin
            idx_d   = idx_q + idx_width_lp'(1);
            state_d = eISSUE;
          end
        end
      end
      eDONE: begin
        if (yumi_i) state_d = eIDLE;
      end
      default: state_d = eIDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready_o     = 1'b0;
    act_v_o     = 1'b0;
    act_ready_o = 1'b0;
    v_o         = 1'b0;
    unique case (state_q)
      eIDLE:   ready_o     = 1'b1;
      eISSUE:  act_v_o     = ~bypass;
      eWAIT:   act_ready_o = 1'b1;
      eDONE:   v_o         = 1'b1;
      default: ready_o     = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bsg_activation_vector_seq.sv
// Directed bench for bsg_activation_vector_seq: a 4-element instance with a stub activation
// unit, plus a 1-element instance driven by hand for the saturation boundary.
module tb_bsg_activation_vector_seq;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         v_i, act_ready_i, act_v_i, yumi_i;
  logic [83:0]  data_i;
  logic [31:0]  act_data_i;
  logic         ready_o, act_v_o, act_ready_o, v_o;
  logic [20:0]  act_ang_o;
  logic [127:0] data_o;

  logic         v1_i, ar1_i, avi1_i, yumi1_i;
  logic [20:0]  data1_i;
  logic [31:0]  ad1_i;
  logic         ready1_o, av1_o, aro1_o, vo1_o;
  logic [20:0]  ang1_o;
  logic [31:0]  do1_o;

  int n_chk = 0;
  int n_bad = 0;
  int stub_lat = 7;
  int act_v_cnt = 0;
  int cyc;
  logic [20:0] ang_log [$];

  always #5 clk = ~clk;

  bsg_activation_vector_seq u_dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .act_ang_o(act_ang_o), .act_v_o(act_v_o), .act_ready_i(act_ready_i),
    .act_data_i(act_data_i), .act_v_i(act_v_i), .act_ready_o(act_ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  bsg_activation_vector_seq #(.els_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v1_i), .data_i(data1_i), .ready_o(ready1_o),
    .act_ang_o(ang1_o), .act_v_o(av1_o), .act_ready_i(ar1_i),
    .act_data_i(ad1_i), .act_v_i(avi1_i), .act_ready_o(aro1_o),
    .v_o(vo1_o), .data_o(do1_o), .yumi_i(yumi1_i)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [83:0] pack4(input logic [20:0] a0, input logic [20:0] a1,
                                        input logic [20:0] a2, input logic [20:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Present a vector until accepted; returns just after the accepting edge
  task automatic send(input logic [83:0] d);
    int guard = 0;
    v_i    = 1'b1;
    data_i = d;
    while (!ready_o && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    v_i = 1'b0;
  endtask

  // Cycles from the accept edge until v_o, with the first post-accept cycle counted as 1
  task automatic wait_vo(output int n);
    n = 1;
    while (!v_o && n < 300) begin
      tick();
      n++;
    end
    if (!v_o) chk("v_o_timeout", 1'b0, 1'b1);
  endtask

  task automatic take();
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
  endtask

  always @(negedge clk) if (act_v_o) act_v_cnt++;

  // Stub activation unit: answers sign-extended angle + 1, stub_lat cycles after handshake
  initial begin : stub
    logic [20:0] ang;
    int g;
    act_v_i    = 1'b0;
    act_data_i = '0;
    forever begin
      @(negedge clk);
      if (act_v_o && act_ready_i) begin
        ang = act_ang_o;
        ang_log.push_back(ang);
        @(posedge clk);
        repeat (stub_lat - 1) @(posedge clk);
        #1;
        act_v_i    = 1'b1;
        act_data_i = {{11{ang[20]}}, ang} + 32'd1;
        g = 0;
        while (g < 10) begin
          @(negedge clk);
          if (act_ready_o) break;
          g++;
        end
        @(posedge clk);
        #1;
        act_v_i = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] held;
    logic         stable;
    reset_i = 1'b1;
    v_i = 1'b0; data_i = '0; act_ready_i = 1'b1; yumi_i = 1'b0;
    v1_i = 1'b0; data1_i = '0; ar1_i = 1'b1; avi1_i = 1'b0; ad1_i = '0; yumi1_i = 1'b0;

    // Reset
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_v", v_o, 1'b0);
    chk("rst_act_v", act_v_o, 1'b0);
    chk("rst_act_ready", act_ready_o, 1'b0);
    chk("rst_data", data_o, 128'h0);
    chk("rst_data1", do1_o, 32'h0);

    // All bypass
    act_v_cnt = 0;
    ang_log.delete();
    send(pack4(21'h040000, 21'h1C0000, 21'h0FFFFF, 21'h100000));
    wait_vo(cyc);
    chk("byp_latency", cyc, 5);
    chk("byp_no_issue", act_v_cnt, 0);
    chk("byp_data", data_o, 128'hFFFF0000_00010000_FFFF0000_00010000);
    take();
    chk("byp_ready_after", ready_o, 1'b1);

    // All issued
    ang_log.delete();
    send(pack4(21'h000000, 21'h008000, 21'h1F8000, 21'h010000));
    wait_vo(cyc);
    chk("iss_count", ang_log.size(), 4);
    if (ang_log.size() == 4) begin
      chk("iss_ang0", ang_log[0], 21'h000000);
      chk("iss_ang1", ang_log[1], 21'h008000);
      chk("iss_ang2", ang_log[2], 21'h1F8000);
      chk("iss_ang3", ang_log[3], 21'h010000);
    end
    chk("iss_data", data_o, 128'h00010001_FFFF8001_00008001_00000001);
    take();

    // Mixed with backpressure on element 1
    ang_log.delete();
    act_ready_i = 1'b0;
    send(pack4(21'h050000, 21'h001000, 21'h1B0000, 21'h002000));
    tick();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (act_v_o !== 1'b1 || act_ang_o !== 21'h001000) stable = 1'b0;
      tick();
    end
    chk("bp_act_v_stable", stable, 1'b1);
    chk("bp_act_ang", act_ang_o, 21'h001000);
    chk("bp_no_issue_yet", ang_log.size(), 0);
    act_ready_i = 1'b1;
    wait_vo(cyc);
    chk("mix_count", ang_log.size(), 2);
    chk("mix_data", data_o, 128'h00002001_FFFF0000_00001001_00010000);

    // Downstream stall
    held = data_o;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (v_o !== 1'b1 || ready_o !== 1'b0 || data_o !== held) stable = 1'b0;
      tick();
    end
    chk("stall_stable", stable, 1'b1);
    chk("stall_data", data_o, 128'h00002001_FFFF0000_00001001_00010000);

    // Back-to-back: v_i held high across the yumi edge
    v_i    = 1'b1;
    data_i = pack4(21'h1C0000, 21'h040000, 21'h1C0000, 21'h040000);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("b2b_idle_ready", ready_o, 1'b1);
    chk("b2b_idle_v", v_o, 1'b0);
    tick();
    v_i = 1'b0;
    chk("b2b_accepted", ready_o, 1'b0);
    wait_vo(cyc);
    chk("b2b_latency", cyc, 5);
    chk("b2b_data", data_o, 128'h00010000_FFFF0000_00010000_FFFF0000);
    take();

    // Reset while waiting on the activation unit, result arrives afterwards
    stub_lat = 20;
    send(pack4(21'h001000, 21'h002000, 21'h003000, 21'h004000));
    tick();
    chk("mid_in_wait", act_ready_o, 1'b1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    repeat (40) tick();
    chk("mid_ready", ready_o, 1'b1);
    chk("mid_v", v_o, 1'b0);
    chk("mid_act_ready", act_ready_o, 1'b0);
    chk("mid_data", data_o, 128'h0);
    stub_lat = 7;

    // els_p = 1, angle just below threshold is issued
    v1_i = 1'b1; data1_i = 21'h03FFFF;
    tick();
    v1_i = 1'b0;
    chk("b1_issue_v", av1_o, 1'b1);
    chk("b1_issue_ang", ang1_o, 21'h03FFFF);
    tick();
    chk("b1_wait", aro1_o, 1'b1);
    avi1_i = 1'b1; ad1_i = 32'h0000_F3A1;
    tick();
    avi1_i = 1'b0;
    chk("b1_issue_done", vo1_o, 1'b1);
    chk("b1_issue_data", do1_o, 32'h0000_F3A1);
    yumi1_i = 1'b1; tick(); yumi1_i = 1'b0;

    // Exactly at +threshold bypasses
    v1_i = 1'b1; data1_i = 21'h040000;
    tick();
    v1_i = 1'b0;
    chk("b1_pos_no_issue", av1_o, 1'b0);
    tick();
    chk("b1_pos_done", vo1_o, 1'b1);
    chk("b1_pos_data", do1_o, 32'h0001_0000);
    yumi1_i = 1'b1; tick(); yumi1_i = 1'b0;

    // Exactly at -threshold bypasses
    v1_i = 1'b1; data1_i = 21'h1C0000;
    tick();
    v1_i = 1'b0;
    chk("b1_neg_no_issue", av1_o, 1'b0);
    tick();
    chk("b1_neg_done", vo1_o, 1'b1);
    chk("b1_neg_data", do1_o, 32'hFFFF_0000);
    yumi1_i = 1'b1; tick(); yumi1_i = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_activation_vector_seq.md
# bsg_activation_vector_seq

Vector sequencer that wraps the single-element blocking tanh activation unit. It accepts a packed vector of `els_p` signed fixed-point angles from the layer datapath and issues elements to the activation unit one at a time. It collects the results in order and presents the packed result vector downstream. Angles whose magnitude is at or beyond the saturation threshold bypass the activation unit and are written as ±1.0 directly, avoiding a full CORDIC and divide pass for them.

## Interface
- `els_p`, 4: elements per vector; must be ≥1.
- `ang_width_p`, 21: signed input angle width. Format has `frac_bits_p` fraction bits.
- `ans_width_p`, 32: signed result width. Format has `frac_bits_p` fraction bits.
- `frac_bits_p`, 16: fraction bits. 1.0 = `1<<frac_bits_p` = 0x10000.
- `sat_ang_p`, `4<<16`: bypass threshold, positive, in angle units.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: reset, synchronous and active-high.
- `v_i` in 1: input vector valid.
- `data_i` in `els_p*ang_width_p`: packed angles; element k is at `[k*ang_width_p +: ang_width_p]`.
- `ready_o` out 1: input vector can be accepted.
- `act_ang_o` out `ang_width_p`: angle sent to the activation unit.
- `act_v_o` out 1: angle valid to the activation unit.
- `act_ready_i` in 1: activation unit ready to accept an angle.
- `act_data_i` in `ans_width_p`: activation result.
- `act_v_i` in 1: activation result valid.
- `act_ready_o` out 1: sequencer is consuming the result; drives the activation unit's consumer-ready.
- `v_o` out 1: result vector valid.
- `data_o` out `els_p*ans_width_p`: packed results in element order.
- `yumi_i` in 1: downstream takes the result vector; legal only while `v_o`=1.

## Operation
- **States:** eIDLE, eISSUE, eWAIT, eDONE.
- **Registers:**
  - Input vector register.
  - Element index `idx`, `$clog2(els_p)` bits, minimum 1 bit.
  - Result buffer, `els_p*ans_width_p` bits.
- **eIDLE:**
  - `ready_o`=1.
  - On `v_i & ready_o`: capture `data_i`, set `idx`=0, go to eISSUE.
- **eISSUE, element `a` = angle[idx]:**
  - Bypass when `a >= sat_ang_p` or `a <= -sat_ang_p`, using a signed compare.
  - Bypass action: write `+0x10000` for positive `a`, or `-0x10000` (sign-extended to `ans_width_p`) for negative `a`, into result[idx]. `act_v_o` stays 0. If `idx == els_p-1` go to eDONE; otherwise increment `idx` and stay in eISSUE.
  - Otherwise: `act_v_o`=1 and `act_ang_o`=`a`. On `act_v_o & act_ready_i`, go to eWAIT.
- **eWAIT:**
  - `act_ready_o`=1.
  - On `act_v_i`: write `act_data_i` into result[idx].
  - If `idx == els_p-1` go to eDONE; otherwise increment `idx` and go to eISSUE.
- **eDONE:**
  - `v_o`=1 and `data_o` = result buffer.
  - On `yumi_i`: go to eIDLE. The new vector is accepted no earlier than the following cycle.
- **Output gating:**
  - `act_ang_o` equals the current element in every state, but is meaningful only while `act_v_o`=1.
  - `act_ready_o` is 0 outside eWAIT.
  - `act_v_i` outside eWAIT is ignored.
- **Results:** written exactly as received. No re-saturation or rounding is applied to activation results.
- **Reset (`reset_i`=1 at a clock edge):**
  - state → eIDLE, `idx` → 0, result buffer → 0.
  - Reset mid-operation abandons the vector. Any in-flight activation result is dropped when it arrives.

## Timing
- **After reset deasserts:** `ready_o`=1; `v_o`, `act_v_o`, `act_ready_o`=0; `data_o`=0.
- **Input acceptance:** a vector accepted at edge T is in eISSUE during the cycle after T.
- **Bypass elements:** exactly 1 cycle each in eISSUE.
- **Issued elements:**
  - 1 or more eISSUE cycles, until `act_ready_i`.
  - Then eWAIT until `act_v_i`; the result is written on that edge.
  - The next element's eISSUE begins in the next cycle.
- **Ordering:** at most one element is in flight. Results are ordered by index regardless of bypass mix.
- **eDONE entry:** in the cycle after the last element is written. `v_o` holds until `yumi_i`, and `data_o` is stable throughout.
- **All-bypass vector latency:** accept at T → `v_o` in cycle T+`els_p`+1.
- **Combinational paths:** `ready_o`, `v_o`, `act_v_o`, `act_ready_o` are state-decoded only. There is no combinational path from any input to any output.

## Test plan
- **Reset:**
  - Hold `reset_i` 3 cycles → `ready_o`=1, `v_o`=0, `act_v_o`=0, `data_o`=0.
  - Mid-eWAIT reset then late `act_v_i` → state eIDLE, `data_o`=0.
- **All bypass:**
  - Angles {0x40000, -0x40000, 0xFFFFF, -0x100000} → no `act_v_o` pulses.
  - `v_o` 5 cycles after accept, `data_o` = {0x00010000, 0xFFFF0000, 0x00010000, 0xFFFF0000}.
- **All issued, stubbed activation:**
  - Angles {0x00000, 0x08000, -0x08000, 0x10000}; the stub returns `ang+1` after 7 cycles.
  - → 4 issues in index order; `data_o` = {0x1, 0x8001, 0xFFFF8001, 0x10001}.
- **Mixed vector with backpressure:**
  - {0x50000, 0x1000, -0x50000, 0x2000}.
  - `act_ready_i` held low 5 cycles on element 1 → `act_v_o` and `act_ang_o`=0x1000 stable throughout.
  - Elements 0 and 2 bypassed to ±0x10000.
- **Downstream stall and back-to-back:**
  - Withhold `yumi_i` 10 cycles → `v_o` and `data_o` stable, `ready_o`=0.
  - After `yumi_i`, assert `v_i` continuously → second vector accepted exactly 1 cycle after the yumi edge.
- **Boundary, `els_p`=1:**
  - Angle = `sat_ang_p`-1 → issued.
  - Angle = `sat_ang_p` → bypass to 0x10000.
  - Angle = -`sat_ang_p` → bypass to 0xFFFF0000.
